// File: rtl/lsu_rd_wb.sv
// Read-return writeback stage: buffers returned AXI read beats in a small FIFO
// and drains them into the local SRAM write port, with beat counting and done/err reporting.
module lsu_rd_wb #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SRAM_AW    = 12,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_vld,
   input  logic [7:0]            start_num,
   output logic                  start_rdy,
   input  logic                  axi_lsu_rvld,
   input  logic [DATA_WIDTH-1:0] axi_lsu_rdata,
   input  logic [1:0]            axi_lsu_rresp,
   input  logic                  axi_lsu_rlast,
   input  logic [SRAM_AW-1:0]    axi_lsu_sram_addr,
   output logic                  lsu_axi_rrdy,
   output logic                  sram_wen,
   output logic [SRAM_AW-1:0]    sram_waddr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic                  sram_wready,
   output logic                  done,
   output logic                  err,
   output logic [7:0]            beat_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = SRAM_AW + DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   logic [7:0]       r_num;
   logic [7:0]       r_beat_cnt;
   logic             r_err;
   logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_fifo_cnt;

   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_unused_rlast;

   // Completion is driven by the beat count, so rlast is deliberately ignored.
   assign w_unused_rlast = axi_lsu_rlast;

   // Handshake outputs depend on registered state only.
   assign start_rdy    = (r_state == S_IDLE);
   assign lsu_axi_rrdy = (r_state == S_BUSY) && (r_fifo_cnt < CNT_W'(FIFO_DEPTH))
                         && (r_beat_cnt != r_num);
   assign sram_wen     = (r_fifo_cnt != '0);
   assign {sram_waddr, sram_wdata} = r_mem[r_rptr];
   assign done         = (r_state == S_DONE);
   assign err          = r_err;
   assign beat_cnt     = r_beat_cnt;

   assign w_accept = axi_lsu_rvld & lsu_axi_rrdy;
   assign w_push   = w_accept & (axi_lsu_rresp == 2'b00);
   assign w_pop    = sram_wen & sram_wready;

   // Command FSM with beat counting and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_num      <= '0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_vld) begin
                  r_num      <= start_num;
                  r_beat_cnt <= '0;
                  r_err      <= 1'b0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
                  if (axi_lsu_rresp != 2'b00) r_err <= 1'b1;
               end
               // Leave on the final accept itself so DRAIN follows the last beat directly.
               if ((r_beat_cnt == r_num) || (w_accept && ((r_beat_cnt + 8'd1) == r_num)))
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if ((r_fifo_cnt == '0) || ((r_fifo_cnt == CNT_W'(1)) && w_pop))
                  r_state <= S_DONE;
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Writeback FIFO; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_fifo_cnt <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {axi_lsu_sram_addr, axi_lsu_rdata};
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

endmodule

// File: doc/lsu_rd_wb.md
# lsu_rd_wb

Read-return writeback stage downstream of the AXI read interface. Consumes returned read beats (data plus the on-chip SRAM address tagged to each beat) through a valid/ready handshake and buffers them in a small FIFO. Drains the FIFO into the local SRAM write port, which can stall. Tracks the expected beat count of a load command, raises a one-cycle done pulse once every beat has been written, and reports a sticky error for non-OKAY responses.

## Interface
- DATA_WIDTH, 64, beat data width
- SRAM_AW, 12, SRAM word address width
- FIFO_DEPTH, 4, writeback buffer entries (power of two, ≥2)
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start_vld  input  1  load command valid from LSU control
- start_num  input  8  number of beats expected for this command
- start_rdy  output  1  block idle, command accepted when start_vld&start_rdy
- axi_lsu_rvld  input  1  returned beat valid
- axi_lsu_rdata  input  DATA_WIDTH  beat data
- axi_lsu_rresp  input  2  AXI response; 2'b00 = OKAY
- axi_lsu_rlast  input  1  last beat of burst (informational; not used for completion)
- axi_lsu_sram_addr  input  SRAM_AW  SRAM destination of beat
- lsu_axi_rrdy  output  1  beat accepted when axi_lsu_rvld&lsu_axi_rrdy
- sram_wen  output  1  SRAM write request
- sram_waddr  output  SRAM_AW  write address
- sram_wdata  output  DATA_WIDTH  write data
- sram_wready  input  1  SRAM accepts write this cycle
- done  output  1  one-cycle completion pulse
- err  output  1  sticky: a non-OKAY beat was received in the current/last command
- beat_cnt  output  8  beats accepted in the current command

## Operation
- FSM states: IDLE, BUSY, DRAIN, DONE.
- IDLE: start_rdy=1. On start_vld, latch start_num, clear beat_cnt and err, and go to BUSY.
- BUSY: lsu_axi_rrdy = (fifo_cnt < FIFO_DEPTH).
  - Each accepted beat increments beat_cnt.
  - An OKAY beat pushes {sram_addr, rdata} into the FIFO.
  - A non-OKAY beat is counted but not pushed, and sets err.
  - When beat_cnt == latched num (checked on registered beat_cnt, including num=0), go to DRAIN.
- DRAIN: lsu_axi_rrdy=0. When FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. err holds its value until the next accepted start.
- lsu_axi_rrdy=0 in IDLE, DRAIN and DONE.
- FIFO pop side: sram_wen = FIFO not empty; sram_waddr and sram_wdata come from the head entry. An entry pops on sram_wen&sram_wready. Writes reach SRAM in beat-arrival order.
- FIFO counters:
  - Simultaneous push and pop: fifo_cnt unchanged.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - fifo_cnt is log2(FIFO_DEPTH)+1 bits.
- Beat count: beat_cnt is 8-bit and does not wrap, because acceptance stops at num ≤ 255. Beats presented in IDLE, DRAIN or DONE are not accepted.
- Reset (any state): FSM→IDLE, FIFO emptied (contents discarded), counters cleared.

## Timing
- Reset values: start_rdy=1, lsu_axi_rrdy=0, sram_wen=0, sram_waddr=0, sram_wdata=0, done=0, err=0, beat_cnt=0.
- All state, counters and FIFO storage are registered. lsu_axi_rrdy, sram_wen and start_rdy are combinational from registered state only; no input→output combinational path.
- Start accepted in cycle N: BUSY in N+1, and lsu_axi_rrdy may assert in N+1.
- Beat accepted in cycle N: sram_wen=1 with that entry at N+1 at the earliest.
- Full FIFO: lsu_axi_rrdy deasserts in the cycle after the push that reaches FIFO_DEPTH.
- Completion latency:
  - Last beat accepted in N → DRAIN at N+1.
  - Last pop completes in cycle M≥N+1 → DONE (done=1) in M+1 → IDLE in M+2.
- num=0: start in N → BUSY N+1 → DRAIN N+2 → DONE N+3.
- Throughput: one beat per cycle sustained with sram_wready=1.

## Test plan
- Basic: start_num=3, OKAY beats to 0x010/0x011/0x012 with data 0xA0..A2 back-to-back, sram_wready=1 → three writes in order, each one cycle after acceptance; done pulses once; err=0; beat_cnt=3.
- Backpressure: start_num=6, sram_wready=0 while beats are offered → exactly 4 accepted, then lsu_axi_rrdy=0. Release sram_wready → remaining 2 accepted; 6 writes in address order; done once.
- Error beat: start_num=3, beat 2 rresp=2'b10 → 2 SRAM writes (beats 1 and 3); err=1 at done and held in IDLE; next start clears err to 0.
- Zero-length: start_num=0 → done exactly 3 cycles after start; lsu_axi_rrdy never asserts; no sram_wen.
- Reset mid-operation: rst pulse in BUSY with 2 FIFO entries and sram_wready=0 → next cycle sram_wen=0, lsu_axi_rrdy=0, start_rdy=1, beat_cnt=0; a following start_num=1 completes normally.
- Simultaneous push/pop plus stray beats: with fifo_cnt=2, beat accepted and write popped in the same cycle → fifo_cnt stays 2. axi_lsu_rvld held in IDLE/DRAIN → never accepted; beat_cnt unchanged.
